operand_fetch: RTL and testbench
================================

# operand_fetch

Decode-to-execute operand stage of the pipelined RV32I core. Takes a decoded instruction from the decode stage and drives the regfile read addresses. It resolves RAW hazards against EX and MEM by forwarding, and inserts one bubble on load-use. It registers the instruction and its operand values into the ID/EX pipeline register under a valid/ready handshake. Writeback needs no bypass because the regfile writes on the falling edge, so a same-cycle WB write is visible to the combinational read.

## Interface
- `CTRL_W`, default 16: width of the opaque control bundle carried to EX. Bit 0 is `is_load`.
- `XLEN`, default 32: datapath width.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `flush` input 1: branch/jump redirect. Kills the register contents and the current input.
- `in_valid` input 1: decode offers an instruction.
- `in_ready` output 1: stage accepts this cycle.
- `in_pc` input XLEN: instruction PC.
- `in_imm` input XLEN: decoded immediate.
- `in_rs1`, `in_rs2`, `in_rd` input 5: register indices.
- `in_use_rs1`, `in_use_rs2` input 1: the operand is actually read.
- `in_ctrl` input CTRL_W: control bundle.
- `rf_a1`, `rf_a2` output 5: regfile read addresses, equal to `in_rs1`/`in_rs2`, combinational.
- `rf_rd1`, `rf_rd2` input XLEN: regfile read data. x0 reads as 0.
- `ex_fwd_valid` input 1, `ex_fwd_rd` input 5, `ex_fwd_data` input XLEN: ALU result of the instruction now in EX.
- `mem_fwd_valid` input 1, `mem_fwd_rd` input 5, `mem_fwd_data` input XLEN: final result (ALU or load data) of the instruction in MEM.
- `out_valid` output 1, `out_ready` input 1: ID/EX handshake.
- `out_pc`, `out_imm`, `out_rs1_val`, `out_rs2_val` output XLEN.
- `out_rd` output 5, `out_ctrl` output CTRL_W.
- `stall_count` output 32: saturating count of load-use bubbles.

## Operation
- Forwarding is done per operand, with priority EX > MEM > RF.
  - EX is selected when `ex_fwd_valid`, `ex_fwd_rd == rs`, and `rs != 0`.
  - MEM is selected under the same rule using the MEM signals.
  - Index 0 always yields 0 and never forwards.
- Load-use stall (`lu`) asserts when `out_valid`, `out_ctrl[0]`, and `out_rd != 0` all hold, and `out_rd` matches `in_rs1` with `in_use_rs1`, or matches `in_rs2` with `in_use_rs2`.
- `in_ready = (!out_valid || out_ready) && !lu && !flush`.
- Register update, highest priority first:
  1. `reset`: clears the register.
  2. `flush`: `out_valid` goes to 0 and the input is dropped.
  3. `in_valid && in_ready`: loads the input with forwarded operands and sets `out_valid` to 1.
  4. `out_ready`: `out_valid` goes to 0. This is the bubble, and includes the `lu` case.
  5. Otherwise: hold.
- `stall_count` increments when `lu && in_valid && out_ready && !flush`. It saturates at 0xFFFF_FFFF.
- States are implicit in `out_valid`:
  - EMPTY → FULL on accept.
  - FULL → FULL on simultaneous drain and accept.
  - FULL → EMPTY on drain with no accept, on `lu`, or on flush.

## Timing
- Accept to `out_valid` takes 1 cycle. Forwarded values are sampled in the accept cycle.
- While `out_valid && !out_ready`, all `out_*` hold stable and `in_ready` is 0.
- Load-use costs exactly one bubble. In the next cycle the load is in MEM, the MEM bypass supplies the data, and `lu` is deasserted.
- Reset values: `out_valid` 0; `out_pc`, `out_imm`, `out_rs1_val`, `out_rs2_val`, `out_rd`, `out_ctrl` all 0; `stall_count` 0.
- Flush and `lu` in the same cycle: the flush wins and no count is taken.
- Reset asserted mid-stall clears the register next edge; any pending input is lost.
- `rf_a1`, `rf_a2` and the forwarding muxes are purely combinational. There is no state besides the output register and the counter.

## Structure
- Package `pipe_pkg` holds:
  - `fwd_sel_e` = {`FWD_RF`, `FWD_EX`, `FWD_MEM`, `FWD_ZERO`}
  - `CTRL_IS_LOAD = 0`
  - the `id_ex_t` struct: pc, imm, rs1_val, rs2_val, rd, ctrl.
- Sub-module `operand_bypass` computes the forward select and value for one operand. It is instantiated twice.
- The top level holds the handshake, `lu` detect, register and counter.

## Test plan
- **Plain accept:** reset, then `in_rs1=5`, `in_rs2=6`, `rf_rd1=0x11`, `rf_rd2=0x22`, no forwards, `out_ready=1` → next cycle `out_valid=1`, `out_rs1_val=0x11`, `out_rs2_val=0x22`.
- **Forward priority:**
  - `ex_fwd_rd=5` with data `0xAA` and `mem_fwd_rd=5` with data `0xBB` → `out_rs1_val=0xAA`.
  - EX invalid → `0xBB`.
  - `in_rs1=0` with both forwards at rd 0 → 0.
- **Load-use:**
  - Stage holds a load with `out_rd=7`; next instruction has `in_rs2=7`, `in_use_rs2=1`.
  - Expect `in_ready=0` for 1 cycle, a bubble (`out_valid=0`), and `stall_count=1`.
  - Then accept with `out_rs2_val = mem_fwd_data`.
  - Repeat with `in_use_rs2=0` → no stall.
- **Backpressure:** `out_ready=0` for 3 cycles with `in_valid=1` → outputs stable, `in_ready=0`. Release → drain and accept in the same edge.
- **Flush/reset:**
  - `flush` during accept → `out_valid=0` next cycle and the instruction is never presented.
  - `reset` during a load-use stall → all outputs 0 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the RV32I pipeline: forwarding selects, control-bit positions
// and the ID/EX pipeline register layout at the default configuration.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_EX,
        FWD_MEM,
        FWD_ZERO
    } fwd_sel_e;

    localparam int unsigned CTRL_IS_LOAD = 0;

    localparam int unsigned ID_EX_XLEN   = 32;
    localparam int unsigned ID_EX_CTRL_W = 16;

    typedef struct packed {
        logic [ID_EX_XLEN-1:0]   pc;
        logic [ID_EX_XLEN-1:0]   imm;
        logic [ID_EX_XLEN-1:0]   rs1_val;
        logic [ID_EX_XLEN-1:0]   rs2_val;
        logic [4:0]              rd;
        logic [ID_EX_CTRL_W-1:0] ctrl;
    } id_ex_t;

endpackage

// File: rtl/operand_bypass.sv
// Per-operand bypass mux: picks EX, MEM or regfile data for one source register,
// with x0 always reading as zero.
module operand_bypass
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [4:0]      rs_i,
    input  logic [XLEN-1:0] rf_data_i,
    input  logic            ex_valid_i,
    input  logic [4:0]      ex_rd_i,
    input  logic [XLEN-1:0] ex_data_i,
    input  logic            mem_valid_i,
    input  logic [4:0]      mem_rd_i,
    input  logic [XLEN-1:0] mem_data_i,
    output logic [XLEN-1:0] val_o
);

    fwd_sel_e sel;

    // Youngest producer wins: EX is newer than MEM.
    always_comb begin
        sel = FWD_RF;
        if (rs_i == 5'd0) begin
            sel = FWD_ZERO;
        end else if (ex_valid_i && (ex_rd_i == rs_i)) begin
            sel = FWD_EX;
        end else if (mem_valid_i && (mem_rd_i == rs_i)) begin
            sel = FWD_MEM;
        end
    end

    always_comb begin
        val_o = rf_data_i;
        unique case (sel)
            FWD_EX:   val_o = ex_data_i;
            FWD_MEM:  val_o = mem_data_i;
            FWD_ZERO: val_o = '0;
            default:  val_o = rf_data_i;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute operand stage: regfile addressing, EX/MEM forwarding,
// load-use bubble insertion and the ID/EX pipeline register.
module operand_fetch
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned XLEN   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic [CTRL_W-1:0] in_ctrl,

    output logic [4:0]        rf_a1,
    output logic [4:0]        rf_a2,
    input  logic [XLEN-1:0]   rf_rd1,
    input  logic [XLEN-1:0]   rf_rd2,

    input  logic              ex_fwd_valid,
    input  logic [4:0]        ex_fwd_rd,
    input  logic [XLEN-1:0]   ex_fwd_data,
    input  logic              mem_fwd_valid,
    input  logic [4:0]        mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [4:0]        out_rd,
    output logic [CTRL_W-1:0] out_ctrl,

    output logic [31:0]       stall_count
);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
    } stage_t;

    logic            valid_q, valid_d;
    stage_t          stage_q, stage_d;
    logic [31:0]     stall_count_q, stall_count_d;

    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            lu;
    logic            accept;

    assign rf_a1 = in_rs1;
    assign rf_a2 = in_rs2;

    operand_bypass #(
        .XLEN (XLEN)
    ) u_bypass_rs1 (
        .rs_i        (in_rs1),
        .rf_data_i   (rf_rd1),
        .ex_valid_i  (ex_fwd_valid),
        .ex_rd_i     (ex_fwd_rd),
        .ex_data_i   (ex_fwd_data),
        .mem_valid_i (mem_fwd_valid),
        .mem_rd_i    (mem_fwd_rd),
        .mem_data_i  (mem_fwd_data),
        .val_o       (rs1_val)
    );

    operand_bypass #(
        .XLEN (XLEN)
    ) u_bypass_rs2 (
        .rs_i        (in_rs2),
        .rf_data_i   (rf_rd2),
        .ex_valid_i  (ex_fwd_valid),
        .ex_rd_i     (ex_fwd_rd),
        .ex_data_i   (ex_fwd_data),
        .mem_valid_i (mem_fwd_valid),
        .mem_rd_i    (mem_fwd_rd),
        .mem_data_i  (mem_fwd_data),
        .val_o       (rs2_val)
    );

    // A load sitting in ID/EX has no data for EX to forward yet; hold the consumer one cycle.
    always_comb begin
        lu = 1'b0;
        if (valid_q && stage_q.ctrl[CTRL_IS_LOAD] && (stage_q.rd != 5'd0)) begin
            lu = ((stage_q.rd == in_rs1) && in_use_rs1) ||
                 ((stage_q.rd == in_rs2) && in_use_rs2);
        end
    end

    assign in_ready = (!valid_q || out_ready) && !lu && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        stage_d = stage_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d         = 1'b1;
            stage_d.pc      = in_pc;
            stage_d.imm     = in_imm;
            stage_d.rs1_val = rs1_val;
            stage_d.rs2_val = rs2_val;
            stage_d.rd      = in_rd;
            stage_d.ctrl    = in_ctrl;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (lu && in_valid && out_ready && !flush && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q       <= 1'b0;
            stage_q       <= '0;
            stall_count_q <= '0;
        end else begin
            valid_q       <= valid_d;
            stage_q       <= stage_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = stage_q.pc;
    assign out_imm     = stage_q.imm;
    assign out_rs1_val = stage_q.rs1_val;
    assign out_rs2_val = stage_q.rs2_val;
    assign out_rd      = stage_q.rd;
    assign out_ctrl    = stage_q.ctrl;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios followed by random traffic, all checked
// against an abstract model of the stage's architectural behaviour.
module tb_operand_fetch;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CTRL_W = 16;

    logic              clk = 1'b0;
    logic              reset, flush;
    logic              in_valid, in_ready;
    logic [XLEN-1:0]   in_pc, in_imm;
    logic [4:0]        in_rs1, in_rs2, in_rd;
    logic              in_use_rs1, in_use_rs2;
    logic [CTRL_W-1:0] in_ctrl;
    logic [4:0]        rf_a1, rf_a2;
    logic [XLEN-1:0]   rf_rd1, rf_rd2;
    logic              ex_fwd_valid, mem_fwd_valid;
    logic [4:0]        ex_fwd_rd, mem_fwd_rd;
    logic [XLEN-1:0]   ex_fwd_data, mem_fwd_data;
    logic              out_valid, out_ready;
    logic [XLEN-1:0]   out_pc, out_imm, out_rs1_val, out_rs2_val;
    logic [4:0]        out_rd;
    logic [CTRL_W-1:0] out_ctrl;
    logic [31:0]       stall_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Model of what the ID/EX register should hold.
    bit              m_valid;
    logic [XLEN-1:0] m_pc, m_imm, m_v1, m_v2;
    logic [4:0]      m_rd;
    logic [CTRL_W-1:0] m_ctrl;
    longint unsigned m_cnt;

    always #5 clk = ~clk;

    operand_fetch #(
        .CTRL_W (CTRL_W),
        .XLEN   (XLEN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_imm        (in_imm),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_rd         (in_rd),
        .in_use_rs1    (in_use_rs1),
        .in_use_rs2    (in_use_rs2),
        .in_ctrl       (in_ctrl),
        .rf_a1         (rf_a1),
        .rf_a2         (rf_a2),
        .rf_rd1        (rf_rd1),
        .rf_rd2        (rf_rd2),
        .ex_fwd_valid  (ex_fwd_valid),
        .ex_fwd_rd     (ex_fwd_rd),
        .ex_fwd_data   (ex_fwd_data),
        .mem_fwd_valid (mem_fwd_valid),
        .mem_fwd_rd    (mem_fwd_rd),
        .mem_fwd_data  (mem_fwd_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_imm       (out_imm),
        .out_rs1_val   (out_rs1_val),
        .out_rs2_val   (out_rs2_val),
        .out_rd        (out_rd),
        .out_ctrl      (out_ctrl),
        .stall_count   (stall_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural operand value: newest producer of the register, x0 is always zero.
    function automatic logic [XLEN-1:0] operand(input logic [4:0] rs, input logic [XLEN-1:0] rf);
        if (rs == 5'd0) return '0;
        if (ex_fwd_valid && ex_fwd_rd == rs) return ex_fwd_data;
        if (mem_fwd_valid && mem_fwd_rd == rs) return mem_fwd_data;
        return rf;
    endfunction

    task automatic idle();
        reset = 0; flush = 0; in_valid = 0; in_pc = '0; in_imm = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_use_rs1 = 0; in_use_rs2 = 0; in_ctrl = '0;
        rf_rd1 = '0; rf_rd2 = '0; ex_fwd_valid = 0; ex_fwd_rd = '0; ex_fwd_data = '0;
        mem_fwd_valid = 0; mem_fwd_rd = '0; mem_fwd_data = '0; out_ready = 0;
    endtask

    // One clock: check combinational outputs, advance the model, clock, check the register.
    task automatic step(input bit do_pre);
        bit hazard, exp_ready;
        #1;
        hazard = m_valid && m_ctrl[0] && (m_rd != 0) &&
                 ((m_rd == in_rs1 && in_use_rs1) || (m_rd == in_rs2 && in_use_rs2));
        exp_ready = (!m_valid || out_ready) && !hazard && !flush;
        if (do_pre) begin
            chk("in_ready", 64'(in_ready), 64'(exp_ready));
            chk("rf_a1", 64'(rf_a1), 64'(in_rs1));
            chk("rf_a2", 64'(rf_a2), 64'(in_rs2));
        end
        if (reset) begin
            m_valid = 0; m_pc = '0; m_imm = '0; m_v1 = '0; m_v2 = '0; m_rd = '0; m_ctrl = '0;
            m_cnt = 0;
        end else begin
            if (hazard && in_valid && out_ready && !flush && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (flush) m_valid = 0;
            else if (in_valid && exp_ready) begin
                m_valid = 1; m_pc = in_pc; m_imm = in_imm; m_rd = in_rd; m_ctrl = in_ctrl;
                m_v1 = operand(in_rs1, rf_rd1);
                m_v2 = operand(in_rs2, rf_rd2);
            end else if (out_ready) m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("stall_count", 64'(stall_count), m_cnt);
        if (m_valid) begin
            chk("out_pc", 64'(out_pc), 64'(m_pc));
            chk("out_imm", 64'(out_imm), 64'(m_imm));
            chk("out_rs1_val", 64'(out_rs1_val), 64'(m_v1));
            chk("out_rs2_val", 64'(out_rs2_val), 64'(m_v2));
            chk("out_rd", 64'(out_rd), 64'(m_rd));
            chk("out_ctrl", 64'(out_ctrl), 64'(m_ctrl));
        end
    endtask

    initial begin
        logic [XLEN-1:0] held_pc, held_v2;
        idle();
        m_valid = 0; m_cnt = 0;
        m_pc = '0; m_imm = '0; m_v1 = '0; m_v2 = '0; m_rd = '0; m_ctrl = '0;

        // Reset state
        reset = 1;
        step(0);
        reset = 0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_rs1", 64'(out_rs1_val), 64'd0);
        chk("rst_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_cnt", 64'(stall_count), 64'd0);

        // Plain accept
        in_valid = 1; in_pc = 32'h100; in_imm = 32'h4; in_rd = 5'd1; in_ctrl = '0;
        in_rs1 = 5'd5; in_rs2 = 5'd6; in_use_rs1 = 1; in_use_rs2 = 1;
        rf_rd1 = 32'h11; rf_rd2 = 32'h22; out_ready = 1;
        step(1);
        chk("plain_valid", 64'(out_valid), 64'd1);
        chk("plain_rs1", 64'(out_rs1_val), 64'h11);
        chk("plain_rs2", 64'(out_rs2_val), 64'h22);

        // Forward priority
        in_pc = 32'h104;
        ex_fwd_valid = 1; ex_fwd_rd = 5'd5; ex_fwd_data = 32'hAA;
        mem_fwd_valid = 1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'hBB;
        step(1);
        chk("fwd_ex", 64'(out_rs1_val), 64'hAA);
        in_pc = 32'h108; ex_fwd_valid = 0;
        step(1);
        chk("fwd_mem", 64'(out_rs1_val), 64'hBB);
        in_pc = 32'h10C; in_rs1 = 5'd0; ex_fwd_valid = 1; ex_fwd_rd = 5'd0; mem_fwd_rd = 5'd0;
        step(1);
        chk("fwd_x0", 64'(out_rs1_val), 64'd0);

        // Load-use: load to x7, consumer of x7 in rs2
        ex_fwd_valid = 0; mem_fwd_valid = 0;
        in_pc = 32'h200; in_ctrl = 16'h0001; in_rd = 5'd7; in_rs1 = 5'd1; in_rs2 = 5'd2;
        step(1);
        in_pc = 32'h204; in_ctrl = 16'h0000; in_rd = 5'd2; in_rs1 = 5'd3; in_rs2 = 5'd7;
        rf_rd2 = 32'h5555;
        #1;
        chk("lu_not_ready", 64'(in_ready), 64'd0);
        step(1);
        chk("lu_bubble", 64'(out_valid), 64'd0);
        chk("lu_count", 64'(stall_count), 64'd1);
        mem_fwd_valid = 1; mem_fwd_rd = 5'd7; mem_fwd_data = 32'hCAFE;
        step(1);
        chk("lu_accept", 64'(out_valid), 64'd1);
        chk("lu_mem_val", 64'(out_rs2_val), 64'hCAFE);

        // Same shape but rs2 not read: no stall
        mem_fwd_valid = 0;
        in_pc = 32'h208; in_ctrl = 16'h0001; in_rd = 5'd7;
        step(1);
        in_pc = 32'h20C; in_ctrl = 16'h0000; in_rd = 5'd2; in_rs2 = 5'd7; in_use_rs2 = 0;
        #1;
        chk("nolu_ready", 64'(in_ready), 64'd1);
        step(1);
        chk("nolu_count", 64'(stall_count), 64'd1);
        chk("nolu_pc", 64'(out_pc), 64'h20C);

        // Backpressure
        held_pc = out_pc; held_v2 = out_rs2_val;
        out_ready = 0; in_pc = 32'h300; in_use_rs2 = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_not_ready", 64'(in_ready), 64'd0);
            step(1);
            chk("bp_pc_stable", 64'(out_pc), 64'(held_pc));
            chk("bp_v2_stable", 64'(out_rs2_val), 64'(held_v2));
        end
        out_ready = 1;
        step(1);
        chk("bp_release_pc", 64'(out_pc), 64'h300);
        chk("bp_release_valid", 64'(out_valid), 64'd1);

        // Flush during accept
        flush = 1; in_pc = 32'hDEAD;
        step(1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        flush = 0; in_valid = 0;
        step(1);
        chk("flush_gone", 64'(out_valid), 64'd0);

        // Reset during a load-use stall
        in_valid = 1; in_pc = 32'h400; in_ctrl = 16'h0001; in_rd = 5'd7; in_rs2 = 5'd2;
        step(1);
        in_pc = 32'h404; in_ctrl = 16'h0000; in_rd = 5'd3; in_rs2 = 5'd7; out_ready = 0;
        step(1);
        chk("stall_hold", 64'(out_valid), 64'd1);
        reset = 1;
        step(1);
        reset = 0;
        chk("rst_stall_valid", 64'(out_valid), 64'd0);
        chk("rst_stall_pc", 64'(out_pc), 64'd0);
        chk("rst_stall_rd", 64'(out_rd), 64'd0);
        chk("rst_stall_cnt", 64'(stall_count), 64'd0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            reset         = ($urandom_range(0, 99) < 2);
            flush         = ($urandom_range(0, 99) < 6);
            in_valid      = ($urandom_range(0, 99) < 75);
            out_ready     = ($urandom_range(0, 99) < 70);
            in_pc         = $urandom;
            in_imm        = $urandom;
            in_rs1        = 5'($urandom_range(0, 7));
            in_rs2        = 5'($urandom_range(0, 7));
            in_rd         = 5'($urandom_range(0, 7));
            in_use_rs1    = 1'($urandom_range(0, 1));
            in_use_rs2    = 1'($urandom_range(0, 1));
            in_ctrl       = 16'($urandom);
            rf_rd1        = (in_rs1 == 0) ? '0 : $urandom;
            rf_rd2        = (in_rs2 == 0) ? '0 : $urandom;
            ex_fwd_valid  = 1'($urandom_range(0, 1));
            ex_fwd_rd     = 5'($urandom_range(0, 7));
            ex_fwd_data   = $urandom;
            mem_fwd_valid = 1'($urandom_range(0, 1));
            mem_fwd_rd    = 5'($urandom_range(0, 7));
            mem_fwd_data  = $urandom;
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
